// File: rtl/update_knn_mac_pipe.sv
// ---------------------------------------------------------------------------
// update_knn_mac_pipe
//
// Pipelined multiply / multiply-accumulate unit for the update_knn datapath.
// It sits between the distance-difference stage and the knn compare/insert
// logic and accepts one operand pair per cycle.
//
//  - Stage 1 captures the operands, the valid bit and the acc_en/acc_clr tags.
//  - The product is formed from the stage-1 registers and then registered
//    through NUM_STAGE-1 stages. The last of these drives dout/out_valid.
//  - An optional accumulator sits one register after dout. It keeps a sticky
//    overflow flag that only acc_clr or reset clears.
//  - ce low freezes every stage, including the accumulator.
//
// Ports
//  clk        in   1          clock, rising edge
//  reset      in   1          synchronous, active-high; wins over ce
//  ce         in   1          clock enable for the whole pipeline
//  in_valid   in   1          qualifies din0/din1 this cycle
//  din0       in   A_WIDTH    multiplicand
//  din1       in   B_WIDTH    multiplier
//  acc_en     in   1          tag: add this product into the accumulator
//  acc_clr    in   1          tag: accumulator restarts at this sample
//  out_valid  out  1          dout holds a fresh product (one pulse per sample)
//  dout       out  P_WIDTH    low P_WIDTH bits of the full product
//  acc_valid  out  1          acc_out was updated by the last enabled edge
//  acc_out    out  ACC_WIDTH  accumulator value (wraps modulo 2^ACC_WIDTH)
//  acc_ovf    out  1          sticky accumulator overflow
// ---------------------------------------------------------------------------
module update_knn_mac_pipe #(
  parameter int A_WIDTH   = 17,
  parameter int B_WIDTH   = 15,
  parameter int P_WIDTH   = 32,
  parameter int NUM_STAGE = 3,
  parameter int SIGNED    = 0,
  parameter int ACC_WIDTH = 40
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce,
  input  logic                 in_valid,
  input  logic [A_WIDTH-1:0]   din0,
  input  logic [B_WIDTH-1:0]   din1,
  input  logic                 acc_en,
  input  logic                 acc_clr,
  output logic                 out_valid,
  output logic [P_WIDTH-1:0]   dout,
  output logic                 acc_valid,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 acc_ovf
);

  // Full product width, widened to P_WIDTH if the caller asks for more bits
  // than the operands can produce so the low P_WIDTH bits are always defined.
  localparam int FULL_W = A_WIDTH + B_WIDTH;
  localparam int MUL_W  = (FULL_W > P_WIDTH) ? FULL_W : P_WIDTH;
  // Index of the final (dout) stage in the post-multiply chain.
  localparam int LAST   = NUM_STAGE - 1;

  if (NUM_STAGE < 2 || NUM_STAGE > 6) begin : g_bad_num_stage
    $error("update_knn_mac_pipe: NUM_STAGE must be in 2..6");
  end
  if (ACC_WIDTH < P_WIDTH) begin : g_bad_acc_width
    $error("update_knn_mac_pipe: ACC_WIDTH must be >= P_WIDTH");
  end

  // -------------------------------------------------------------------------
  // Arithmetic helpers
  // -------------------------------------------------------------------------
  function automatic logic signed [MUL_W-1:0] ext_a(input logic [A_WIDTH-1:0] a);
    if (SIGNED != 0) return MUL_W'($signed(a));
    return MUL_W'(a);
  endfunction

  function automatic logic signed [MUL_W-1:0] ext_b(input logic [B_WIDTH-1:0] b);
    if (SIGNED != 0) return MUL_W'($signed(b));
    return MUL_W'(b);
  endfunction

  // Operands are extended to the result width first, so the low MUL_W bits
  // of the product are exact for either signedness.
  function automatic logic [P_WIDTH-1:0] mul_trunc(input logic [A_WIDTH-1:0] a,
                                                   input logic [B_WIDTH-1:0] b);
    logic signed [MUL_W-1:0] full;
    full = ext_a(a) * ext_b(b);
    return full[P_WIDTH-1:0];
  endfunction

  function automatic logic [ACC_WIDTH-1:0] ext_acc(input logic [P_WIDTH-1:0] p);
    if (SIGNED != 0) return ACC_WIDTH'($signed(p));
    return ACC_WIDTH'(p);
  endfunction

  // Unsigned: carry out of the MSB. Signed: same-sign operands whose sum
  // has the other sign.
  function automatic logic add_overflow(input logic [ACC_WIDTH-1:0] base,
                                        input logic [ACC_WIDTH-1:0] addend,
                                        input logic [ACC_WIDTH-1:0] sum,
                                        input logic                 carry);
    if (SIGNED != 0)
      return (base[ACC_WIDTH-1] == addend[ACC_WIDTH-1]) &&
             (sum[ACC_WIDTH-1] != base[ACC_WIDTH-1]);
    return carry;
  endfunction

  // -------------------------------------------------------------------------
  // Pipeline state
  //  index 0      : stage-1 operand registers (din0_p0/din1_p0)
  //  index 1..LAST: product registers, LAST drives dout
  // Valid and tags travel in packed vectors alongside the data.
  // -------------------------------------------------------------------------
  logic [A_WIDTH-1:0] din0_p0;
  logic [B_WIDTH-1:0] din1_p0;
  logic [LAST:0]      vld_p;
  logic [LAST:0]      en_p;
  logic [LAST:0]      clr_p;
  logic [P_WIDTH-1:0] prod_p [1:LAST];
  logic [P_WIDTH-1:0] prod_d [1:LAST];

  // Next value for each product register.
  always_comb begin
    prod_d[1] = mul_trunc(din0_p0, din1_p0);
    for (int s = 2; s <= LAST; s++) begin
      prod_d[s] = prod_p[s-1];
    end
  end

  always_ff @(posedge clk) begin
    // --- stage 1 operands and intermediate products: data only, no reset ---
    if (ce) begin
      din0_p0 <= din0;
      din1_p0 <= din1;
      for (int s = 1; s < LAST; s++) begin
        prod_p[s] <= prod_d[s];
      end
    end
    // --- valid/tag chain and the dout stage ---
    if (reset) begin
      vld_p        <= '0;
      en_p         <= '0;
      clr_p        <= '0;
      prod_p[LAST] <= '0;
    end else if (ce) begin
      vld_p <= {vld_p[LAST-1:0], in_valid};
      en_p  <= {en_p[LAST-1:0],  acc_en};
      clr_p <= {clr_p[LAST-1:0], acc_clr};
      // Bubbles leave dout untouched.
      if (vld_p[LAST-1]) prod_p[LAST] <= prod_d[LAST];
    end
  end

  assign out_valid = vld_p[LAST];
  assign dout      = prod_p[LAST];

  // -------------------------------------------------------------------------
  // Accumulator stage (one register after dout)
  // -------------------------------------------------------------------------
  logic [ACC_WIDTH-1:0] acc_base;
  logic [ACC_WIDTH-1:0] acc_addend;
  logic [ACC_WIDTH-1:0] acc_sum;
  logic                 acc_carry;
  logic                 acc_add_ovf;

  always_comb begin
    // acc_clr on the sample makes the sum start from this product.
    acc_base                = clr_p[LAST] ? '0 : acc_out;
    acc_addend              = ext_acc(prod_p[LAST]);
    {acc_carry, acc_sum}    = {1'b0, acc_base} + {1'b0, acc_addend};
    acc_add_ovf             = add_overflow(acc_base, acc_addend, acc_sum, acc_carry);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_out   <= '0;
      acc_valid <= 1'b0;
      acc_ovf   <= 1'b0;
    end else if (ce) begin
      if (vld_p[LAST] && en_p[LAST]) begin
        acc_out   <= acc_sum;
        acc_valid <= 1'b1;
        acc_ovf   <= (acc_ovf & ~clr_p[LAST]) | acc_add_ovf;
      end else if (clr_p[LAST]) begin
        acc_out   <= '0;
        acc_valid <= 1'b1;
        acc_ovf   <= 1'b0;
      end else begin
        acc_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_update_knn_mac_pipe.sv
// ---------------------------------------------------------------------------
// tb_update_knn_mac_pipe
//
// Three instances share one stimulus stream:
//  u0: unsigned, NUM_STAGE=3, ACC_WIDTH=40 (default build)
//  u1: signed,   NUM_STAGE=5, ACC_WIDTH=40
//  u2: unsigned, NUM_STAGE=2, ACC_WIDTH=33
// A reference model predicts every output from a history of accepted
// samples indexed by enabled-edge count, using plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_update_knn_mac_pipe;

  logic        clk = 1'b0;
  logic        reset, ce, in_valid, acc_en, acc_clr;
  logic [16:0] din0;
  logic [14:0] din1;

  logic [2:0]        act_ov, act_av, act_ovf;
  logic [2:0][31:0]  act_dout;
  logic [2:0][39:0]  act_acc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  update_knn_mac_pipe #(.NUM_STAGE(3), .SIGNED(0), .ACC_WIDTH(40)) u0 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(act_ov[0]), .dout(act_dout[0]),
    .acc_valid(act_av[0]), .acc_out(act_acc[0]), .acc_ovf(act_ovf[0]));

  update_knn_mac_pipe #(.NUM_STAGE(5), .SIGNED(1), .ACC_WIDTH(40)) u1 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(act_ov[1]), .dout(act_dout[1]),
    .acc_valid(act_av[1]), .acc_out(act_acc[1]), .acc_ovf(act_ovf[1]));

  update_knn_mac_pipe #(.NUM_STAGE(2), .SIGNED(0), .ACC_WIDTH(33)) u2 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(act_ov[2]), .dout(act_dout[2]),
    .acc_valid(act_av[2]), .acc_out(act_acc[2][32:0]), .acc_ovf(act_ovf[2]));
  assign act_acc[2][39:33] = '0;

  // ---------------- reference model ----------------
  function automatic int ns_of(input int i);
    case (i) 0: return 3; 1: return 5; default: return 2; endcase
  endfunction
  function automatic bit sg_of(input int i);
    return (i == 1);
  endfunction
  function automatic int accw_of(input int i);
    return (i == 2) ? 33 : 40;
  endfunction

  // Low 32 bits of the mathematical product.
  function automatic longint model_prod(input int i, input logic [16:0] a, input logic [14:0] b);
    longint va, vb;
    if (sg_of(i)) begin va = $signed(a); vb = $signed(b); end
    else begin va = a; vb = b; end
    return (va * vb) & 64'hFFFF_FFFF;
  endfunction

  // Numeric value of a w-bit pattern.
  function automatic longint as_val(input longint bits, input int w, input bit sg);
    longint one;
    one = 1;
    if (sg && bits[w-1]) return bits - (one << w);
    return bits;
  endfunction

  bit          hv   [0:4095];
  bit          hen  [0:4095];
  bit          hclr [0:4095];
  logic [16:0] ha   [0:4095];
  logic [14:0] hb   [0:4095];
  int n_edge = 0;
  int floor_idx = 0;

  logic [2:0]       exp_ov = '0, exp_av = '0, exp_ovf = '0;
  logic [2:0][31:0] exp_dout = '0;
  logic [2:0][39:0] exp_acc = '0;

  always @(posedge clk) begin
    int io, ia, w;
    bit ok, sv, sen, sclr, sg, ovf;
    longint one, base, addv, sum;
    one = 1;
    if (reset) begin
      exp_ov = '0; exp_av = '0; exp_ovf = '0; exp_dout = '0; exp_acc = '0;
      floor_idx = n_edge;
    end else if (ce) begin
      hv[n_edge] = in_valid; hen[n_edge] = acc_en; hclr[n_edge] = acc_clr;
      ha[n_edge] = din0; hb[n_edge] = din1;
      n_edge++;
      for (int i = 0; i < 3; i++) begin
        sg = sg_of(i);
        w  = accw_of(i);
        // accumulator consumes the sample that was on dout before this edge
        ia   = n_edge - ns_of(i) - 1;
        ok   = (ia >= floor_idx);
        sv   = ok && hv[ia];
        sen  = ok && hen[ia];
        sclr = ok && hclr[ia];
        if (sv && sen) begin
          base = sclr ? 0 : as_val(longint'(exp_acc[i]), w, sg);
          addv = as_val(model_prod(i, ha[ia], hb[ia]), 32, sg);
          sum  = base + addv;
          if (sg) ovf = (sum < -(one << (w-1))) || (sum > (one << (w-1)) - 1);
          else    ovf = (sum >= (one << w));
          exp_acc[i] = 40'(sum & ((one << w) - 1));
          exp_av[i]  = 1'b1;
          exp_ovf[i] = (sclr ? 1'b0 : exp_ovf[i]) | ovf;
        end else if (sclr) begin
          exp_acc[i] = '0; exp_av[i] = 1'b1; exp_ovf[i] = 1'b0;
        end else begin
          exp_av[i] = 1'b0;
        end
        // dout shows the sample accepted NUM_STAGE-1 enabled edges ago
        io = n_edge - ns_of(i);
        if (io >= floor_idx && hv[io]) begin
          exp_ov[i]   = 1'b1;
          exp_dout[i] = 32'(model_prod(i, ha[io], hb[io]));
        end else begin
          exp_ov[i] = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Inputs change on the falling edge; outputs are read on the next one.
  task automatic drive(input bit c, input bit v, input logic [16:0] a, input logic [14:0] b,
                       input bit en, input bit clr);
    ce = c; in_valid = v; din0 = a; din1 = b; acc_en = en; acc_clr = clr;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1, 0, '0, '0, 0, 0);
  endtask

  task automatic test_reset;
    reset = 1; ce = 0; in_valid = 0; din0 = '0; din1 = '0; acc_en = 0; acc_clr = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (act_ov[i] !== 1'b0 || act_av[i] !== 1'b0 || act_ovf[i] !== 1'b0 ||
          act_dout[i] !== 32'h0 || act_acc[i] !== 40'h0) begin
        errors++;
        $display("FAIL reset_state u%0d: ov=%b dout=%h av=%b acc=%h ovf=%b, expected all zero",
                 i, act_ov[i], act_dout[i], act_av[i], act_acc[i], act_ovf[i]);
      end
    end
    reset = 0;
  endtask

  task automatic test_unsigned_max;
    idle(2);
    drive(1, 1, 17'h1FFFF, 15'h7FFF, 0, 0);
    idle(1);
    checks++;
    if (act_ov[0] !== 1'b0) begin
      errors++; $display("FAIL umax_early_valid: out_valid=%b, expected 0", act_ov[0]);
    end
    idle(1);
    checks++;
    if (act_ov[0] !== 1'b1) begin
      errors++; $display("FAIL umax_valid: out_valid=%b, expected 1", act_ov[0]);
    end
    checks++;
    if (act_dout[0] !== 32'hFFFD8001) begin
      errors++; $display("FAIL umax_dout: dout=%h, expected fffd8001", act_dout[0]);
    end
    idle(1);
    checks++;
    if (act_ov[0] !== 1'b0 || act_dout[0] !== 32'hFFFD8001) begin
      errors++;
      $display("FAIL umax_hold: out_valid=%b dout=%h, expected 0 / fffd8001", act_ov[0], act_dout[0]);
    end
  endtask

  task automatic test_signed;
    idle(6);
    drive(1, 1, 17'h1FFFD, 15'd5, 1, 1);
    drive(1, 1, 17'd2, 15'd4, 1, 0);
    idle(3);
    checks++;
    if (act_ov[1] !== 1'b1 || act_dout[1] !== 32'hFFFFFFF1) begin
      errors++;
      $display("FAIL signed_dout: out_valid=%b dout=%h, expected 1 / fffffff1", act_ov[1], act_dout[1]);
    end
    idle(1);
    checks++;
    if (act_av[1] !== 1'b1 || act_acc[1] !== 40'hFF_FFFF_FFF1) begin
      errors++;
      $display("FAIL signed_acc1: acc_valid=%b acc=%h, expected 1 / fffffffff1", act_av[1], act_acc[1]);
    end
    idle(1);
    checks++;
    if (act_av[1] !== 1'b1 || act_acc[1] !== 40'hFF_FFFF_FFF9) begin
      errors++;
      $display("FAIL signed_acc2: acc_valid=%b acc=%h, expected 1 / fffffffff9", act_av[1], act_acc[1]);
    end
  endtask

  task automatic test_back_to_back;
    int pulses, last_d;
    bit c;
    pulses = 0; last_d = -1;
    idle(6);
    for (int d = 0; d < 15; d++) begin
      c = !(d == 4 || d == 5);
      if (d < 4)       drive(1, 1, 17'(d), 15'(d + 1), 1, d == 0);
      else if (d < 6)  drive(0, 1, 17'($urandom), 15'($urandom), 1, 1);
      else if (d < 10) drive(1, 1, 17'(d - 2), 15'(d - 1), 1, 0);
      else             drive(1, 0, '0, '0, 0, 0);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (act_ov[i] !== exp_ov[i] || act_dout[i] !== exp_dout[i] || act_av[i] !== exp_av[i] ||
            act_acc[i] !== exp_acc[i] || act_ovf[i] !== exp_ovf[i]) begin
          errors++;
          $display("FAIL b2b_model u%0d d=%0d: ov=%b dout=%h av=%b acc=%h ovf=%b, expected ov=%b dout=%h av=%b acc=%h ovf=%b",
                   i, d, act_ov[i], act_dout[i], act_av[i], act_acc[i], act_ovf[i],
                   exp_ov[i], exp_dout[i], exp_av[i], exp_acc[i], exp_ovf[i]);
        end
      end
      if (c && act_ov[0]) begin
        checks++;
        if (act_dout[0] !== 32'(pulses * (pulses + 1))) begin
          errors++;
          $display("FAIL b2b_product #%0d: dout=%0d, expected %0d", pulses, act_dout[0], pulses * (pulses + 1));
        end
        pulses++;
        last_d = d;
      end
    end
    checks++;
    if (pulses != 8) begin
      errors++; $display("FAIL b2b_count: pulses=%0d, expected 8", pulses);
    end
    checks++;
    if (last_d != 11) begin
      errors++; $display("FAIL b2b_last_timing: last pulse at cycle %0d, expected 11", last_d);
    end
  endtask

  task automatic test_accumulate;
    idle(6);
    drive(1, 1, 17'd1, 15'd1, 1, 1);
    drive(1, 1, 17'd2, 15'd2, 1, 0);
    drive(1, 1, 17'd3, 15'd3, 1, 0);
    drive(1, 1, 17'd4, 15'd4, 1, 0);
    drive(1, 0, '0, '0, 0, 1);
    idle(1);
    checks++;
    if (act_ov[0] !== 1'b1 || act_dout[0] !== 32'd16) begin
      errors++; $display("FAIL acc_last_dout: out_valid=%b dout=%0d, expected 1 / 16", act_ov[0], act_dout[0]);
    end
    idle(1);
    checks++;
    if (act_av[0] !== 1'b1 || act_acc[0] !== 40'd30) begin
      errors++; $display("FAIL acc_sum: acc_valid=%b acc=%0d, expected 1 / 30", act_av[0], act_acc[0]);
    end
    idle(1);
    checks++;
    if (act_av[0] !== 1'b1 || act_acc[0] !== 40'd0) begin
      errors++; $display("FAIL acc_clr_bubble: acc_valid=%b acc=%0d, expected 1 / 0", act_av[0], act_acc[0]);
    end
    idle(1);
    checks++;
    if (act_av[0] !== 1'b0) begin
      errors++; $display("FAIL acc_valid_pulse: acc_valid=%b, expected 0", act_av[0]);
    end
  endtask

  task automatic test_overflow;
    idle(6);
    drive(1, 1, 17'h1FFFF, 15'h7FFF, 1, 1);
    drive(1, 1, 17'h1FFFF, 15'h7FFF, 1, 0);
    drive(1, 1, 17'h1FFFF, 15'h7FFF, 1, 0);
    idle(1);
    checks++;
    if (act_acc[2] !== 40'h01_FFFB_0002 || act_ovf[2] !== 1'b0) begin
      errors++; $display("FAIL ovf_after2: acc=%h ovf=%b, expected 01fffb0002 / 0", act_acc[2], act_ovf[2]);
    end
    idle(1);
    checks++;
    if (act_acc[2] !== 40'h00_FFF8_8003 || act_ovf[2] !== 1'b1) begin
      errors++; $display("FAIL ovf_after3: acc=%h ovf=%b, expected 00fff88003 / 1", act_acc[2], act_ovf[2]);
    end
    idle(2);
    checks++;
    if (act_ovf[2] !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky: ovf=%b, expected 1", act_ovf[2]);
    end
    drive(1, 0, '0, '0, 0, 1);
    idle(2);
    checks++;
    if (act_ovf[2] !== 1'b0 || act_acc[2] !== 40'h0 || act_av[2] !== 1'b1) begin
      errors++;
      $display("FAIL ovf_clear: ovf=%b acc=%h acc_valid=%b, expected 0 / 0 / 1", act_ovf[2], act_acc[2], act_av[2]);
    end
  endtask

  task automatic test_random;
    bit c, v, en, clr;
    logic [16:0] a;
    logic [14:0] b;
    for (int k = 0; k < 400; k++) begin
      c   = ($urandom % 10) != 0;
      v   = ($urandom % 10) < 7;
      en  = ($urandom % 10) < 6;
      clr = ($urandom % 16) == 0;
      a   = (($urandom % 4) == 0) ? 17'h1FFFF : 17'($urandom);
      b   = (($urandom % 4) == 0) ? 15'h7FFF  : 15'($urandom);
      drive(c, v, a, b, en, clr);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (act_ov[i] !== exp_ov[i] || act_dout[i] !== exp_dout[i] || act_av[i] !== exp_av[i] ||
            act_acc[i] !== exp_acc[i] || act_ovf[i] !== exp_ovf[i]) begin
          errors++;
          $display("FAIL random_model u%0d k=%0d: ov=%b dout=%h av=%b acc=%h ovf=%b, expected ov=%b dout=%h av=%b acc=%h ovf=%b",
                   i, k, act_ov[i], act_dout[i], act_av[i], act_acc[i], act_ovf[i],
                   exp_ov[i], exp_dout[i], exp_av[i], exp_acc[i], exp_ovf[i]);
        end
      end
    end
  endtask

  task automatic test_reset_inflight;
    idle(6);
    drive(1, 1, 17'd5, 15'd7, 1, 1);
    idle(6);
    drive(1, 1, 17'd9, 15'd9, 1, 0);
    drive(1, 1, 17'd10, 15'd10, 1, 0);
    reset = 1;
    drive(0, 0, '0, '0, 0, 0);
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (act_ov[i] !== 1'b0 || act_av[i] !== 1'b0 || act_ovf[i] !== 1'b0 ||
          act_dout[i] !== 32'h0 || act_acc[i] !== 40'h0) begin
        errors++;
        $display("FAIL reset_inflight u%0d: ov=%b dout=%h av=%b acc=%h ovf=%b, expected all zero",
                 i, act_ov[i], act_dout[i], act_av[i], act_acc[i], act_ovf[i]);
      end
    end
    for (int k = 0; k < 8; k++) begin
      idle(1);
      checks++;
      if (act_ov !== 3'b000 || act_av !== 3'b000 || act_acc !== '0) begin
        errors++;
        $display("FAIL reset_dropped k=%0d: out_valid=%b acc_valid=%b, expected 000 / 000", k, act_ov, act_av);
      end
    end
  endtask

  initial begin
    test_reset;
    test_unsigned_max;
    test_signed;
    test_back_to_back;
    test_accumulate;
    test_overflow;
    test_random;
    test_reset_inflight;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
